// File: rtl/alu_muldiv_seq.sv
// Sequential EX-stage ALU with iterative multiply/divide into HI/LO.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   in_valid/in_ready   issue handshake; in_ready high only while IDLE
//   alu_op, funct       operation select (funct decoded when alu_op==2)
//   shamt               shift amount for SLL/SRL/SRA
//   op_a, op_b          operands
//   out_valid           one-cycle completion pulse
//   result              registered result
//   overflow, div_zero, illegal  status flags, valid with out_valid
module alu_muldiv_seq #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             div_zero,
  output logic             illegal
);

  localparam int unsigned W = WIDTH;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_SRL   = 6'd2;
  localparam logic [5:0] F_SRA   = 6'd3;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t         state, state_d;
  logic           in_ready_d, out_valid_d, overflow_d, div_zero_d, illegal_d;
  logic [W-1:0]   result_d, hi, hi_d, lo, lo_d;
  logic [W-1:0]   acc_hi, acc_hi_d, acc_lo, acc_lo_d, dvs, dvs_d;
  logic           neg_q, neg_q_d, neg_r, neg_r_d;
  logic [SHW-1:0] cnt, cnt_d;

  logic [W-1:0]   sum, diff, a_mag, b_mag, sc_res;
  logic           a_neg, b_neg, sc_ovf, sc_ill, start_mul, start_div, last;
  logic [W:0]     mul_sum, div_sh;
  logic [W-1:0]   mul_hi, mul_lo, div_rem, div_quo, fin_q, fin_r;
  logic [2*W-1:0] prod, prod_s;
  logic           div_ge;

  // Next-state, datapath and registered-output values.
  always_comb begin
    state_d     = state;
    out_valid_d = 1'b0;
    result_d    = result;
    overflow_d  = overflow;
    div_zero_d  = div_zero;
    illegal_d   = illegal;
    hi_d        = hi;
    lo_d        = lo;
    acc_hi_d    = acc_hi;
    acc_lo_d    = acc_lo;
    dvs_d       = dvs;
    neg_q_d     = neg_q;
    neg_r_d     = neg_r;
    cnt_d       = cnt;
    sc_res      = '0;
    sc_ovf      = 1'b0;
    sc_ill      = 1'b0;
    start_mul   = 1'b0;
    start_div   = 1'b0;

    sum   = op_a + op_b;
    diff  = op_a - op_b;
    // funct[0]==0 selects the signed variant of MULT/DIV
    a_neg = ~funct[0] & op_a[W-1];
    b_neg = ~funct[0] & op_b[W-1];
    a_mag = a_neg ? -op_a : op_a;
    b_mag = b_neg ? -op_b : op_b;
    last  = (cnt == SHW'(W-1));

    // Shift-add step: conditionally add multiplicand, shift {hi,lo} right.
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dvs} : '0);
    mul_hi  = mul_sum[W:1];
    mul_lo  = {mul_sum[0], acc_lo[W-1:1]};
    prod    = {mul_hi, mul_lo};
    prod_s  = neg_q ? -prod : prod;

    // Restoring step: shift in next dividend bit, subtract if it fits.
    div_sh  = {acc_hi, acc_lo[W-1]};
    div_ge  = (div_sh >= {1'b0, dvs});
    div_rem = div_ge ? W'(div_sh - {1'b0, dvs}) : div_sh[W-1:0];
    div_quo = {acc_lo[W-2:0], div_ge};
    fin_q   = neg_q ? -div_quo : div_quo;
    fin_r   = neg_r ? -div_rem : div_rem;

    unique case (alu_op)
      2'd0: begin
        sc_res = sum;
        sc_ovf = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]);
      end
      2'd1: sc_res = op_a & op_b;
      2'd3: begin
        sc_res = diff;
        sc_ovf = (op_a[W-1] != op_b[W-1]) && (diff[W-1] != op_a[W-1]);
      end
      default: begin
        // Shifts act on op_b (the rt operand).
        case (funct)
          F_SLL:  sc_res = op_b << shamt;
          F_SRL:  sc_res = op_b >> shamt;
          F_SRA:  sc_res = $signed(op_b) >>> shamt;
          F_ADD: begin
            sc_res = sum;
            sc_ovf = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]);
          end
          F_SUB: begin
            sc_res = diff;
            sc_ovf = (op_a[W-1] != op_b[W-1]) && (diff[W-1] != op_a[W-1]);
          end
          F_AND:  sc_res = op_a & op_b;
          F_OR:   sc_res = op_a | op_b;
          F_SLT:  sc_res = W'($signed(op_a) < $signed(op_b));
          F_MFHI: sc_res = hi;
          F_MFLO: sc_res = lo;
          F_MULT, F_MULTU: start_mul = 1'b1;
          F_DIV, F_DIVU: begin
            start_div = (op_b != '0);
            sc_res    = '1;
          end
          default: sc_ill = 1'b1;
        endcase
      end
    endcase

    unique case (state)
      IDLE: begin
        if (in_valid) begin
          acc_hi_d = '0;
          cnt_d    = '0;
          neg_q_d  = a_neg ^ b_neg;
          neg_r_d  = a_neg;
          if (start_mul) begin
            state_d  = MUL;
            acc_lo_d = b_mag;
            dvs_d    = a_mag;
          end else if (start_div) begin
            state_d  = DIV;
            acc_lo_d = a_mag;
            dvs_d    = b_mag;
          end else begin
            out_valid_d = 1'b1;
            result_d    = sc_res;
            overflow_d  = sc_ovf;
            illegal_d   = sc_ill;
            // Only a DIV/DIVU reaching here has a zero divisor.
            div_zero_d  = (alu_op == 2'd2) && (funct == F_DIV || funct == F_DIVU);
            if (div_zero_d) begin
              lo_d = '1;
              hi_d = op_a;
            end
          end
        end
      end
      MUL: begin
        acc_hi_d = mul_hi;
        acc_lo_d = mul_lo;
        cnt_d    = cnt + SHW'(1);
        if (last) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          hi_d        = prod_s[2*W-1:W];
          lo_d        = prod_s[W-1:0];
          result_d    = prod_s[W-1:0];
          overflow_d  = 1'b0;
          div_zero_d  = 1'b0;
          illegal_d   = 1'b0;
        end
      end
      DIV: begin
        acc_hi_d = div_rem;
        acc_lo_d = div_quo;
        cnt_d    = cnt + SHW'(1);
        if (last) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          hi_d        = fin_r;
          lo_d        = fin_q;
          result_d    = fin_q;
          overflow_d  = 1'b0;
          div_zero_d  = 1'b0;
          illegal_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      div_zero  <= 1'b0;
      illegal   <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      dvs       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      result    <= result_d;
      overflow  <= overflow_d;
      div_zero  <= div_zero_d;
      illegal   <= illegal_d;
      hi        <= hi_d;
      lo        <= lo_d;
      acc_hi    <= acc_hi_d;
      acc_lo    <= acc_lo_d;
      dvs       <= dvs_d;
      neg_q     <= neg_q_d;
      neg_r     <= neg_r_d;
      cnt       <= cnt_d;
    end
  end

endmodule
